// File: rtl/matvec_sched_if.sv
// matvec_sched_if: requester and engine signal bundle for matvec_sched.
// MATVEC_SCHED_TIMEOUT_EN adds the sticky err_o watchdog flag.
interface matvec_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int IN_DIM  = 128,
    parameter int OUT_DIM = 128
);
    localparam int AW = $clog2(OUT_DIM * IN_DIM);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]          req_i;
    logic [NUM_REQ*IN_DIM*8-1:0] in_vec_i;
    logic [NUM_REQ-1:0]          grant_o;
    logic [NUM_REQ-1:0]          done_o;
    logic [OUT_DIM*8-1:0]        out_vec_o;
    logic                        busy_o;
    logic                        eng_start_o;
    logic [IN_DIM*8-1:0]         eng_in_vec_o;
    logic [AW-1:0]               eng_weight_addr_i;
    logic [OUT_DIM*8-1:0]        eng_out_vec_i;
    logic                        eng_done_i;
    logic [IW+AW-1:0]            weight_addr_o;
`ifdef MATVEC_SCHED_TIMEOUT_EN
    logic                        err_o;
`endif
    modport slave (
        input  req_i, in_vec_i, eng_weight_addr_i, eng_out_vec_i, eng_done_i,
        output grant_o, done_o, out_vec_o, busy_o, eng_start_o, eng_in_vec_o, weight_addr_o
`ifdef MATVEC_SCHED_TIMEOUT_EN
        , output err_o
`endif
    );
    modport master (
        output req_i, in_vec_i, eng_weight_addr_i, eng_out_vec_i, eng_done_i,
        input  grant_o, done_o, out_vec_o, busy_o, eng_start_o, eng_in_vec_o, weight_addr_o
`ifdef MATVEC_SCHED_TIMEOUT_EN
        , input err_o
`endif
    );
endinterface

// File: rtl/matvec_sched.sv
// matvec_sched: round-robin sharing of one matvec_int8 engine and its weight BRAM among NUM_REQ requesters.
// Define MATVEC_SCHED_TIMEOUT_EN to add a RUN watchdog (parameter TIMEOUT) with sticky err_o.
module matvec_sched #(
    parameter int NUM_REQ = 4,
    parameter int IN_DIM  = 128,
    parameter int OUT_DIM = 128
`ifdef MATVEC_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT = OUT_DIM * IN_DIM + 16
`endif
) (
    input logic           clk_i,
    input logic           rst_i,
    matvec_sched_if.slave bus
);
    localparam int AW = $clog2(OUT_DIM * IN_DIM);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;
    state_t               r_state;
    logic [IW-1:0]        r_owner;
    logic [IW-1:0]        r_rr;
    logic [IW-1:0]        w_pick;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic [OUT_DIM*8-1:0] r_out;
    logic [IN_DIM*8-1:0]  r_in;
    logic                 r_start;
    logic                 w_tmo;
    logic                 w_fin;
`ifdef MATVEC_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign w_tmo = !bus.eng_done_i && r_cnt == CW'(TIMEOUT - 1);
    assign bus.err_o = r_err;
`else
    assign w_tmo = 1'b0;
`endif
    assign w_fin = bus.eng_done_i || w_tmo;
    // Scan downward so the nearest set bit after r_rr wins; i == NUM_REQ wraps onto r_rr itself.
    always_comb begin
        w_pick = r_owner;
        for (int i = NUM_REQ; i >= 1; i--)
            if (bus.req_i[r_rr + IW'(i)]) w_pick = r_rr + IW'(i);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_rr    <= IW'(NUM_REQ - 1);
            r_grant <= '0;
            r_done  <= '0;
            r_out   <= '0;
            r_in    <= '0;
            r_start <= 1'b0;
`ifdef MATVEC_SCHED_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            r_done  <= '0;
            case (r_state)
                IDLE: if (|bus.req_i) begin
                    r_owner <= w_pick;
                    r_in    <= bus.in_vec_i[w_pick*IN_DIM*8 +: IN_DIM*8];
                    r_grant <= NUM_REQ'(1) << w_pick;
                    r_start <= 1'b1;
                    r_state <= START;
                end
                START: begin
`ifdef MATVEC_SCHED_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= RUN;
                end
                RUN: begin
`ifdef MATVEC_SCHED_TIMEOUT_EN
                    r_cnt <= r_cnt + 1'b1;
                    if (w_tmo) r_err <= 1'b1;
`endif
                    if (w_fin) begin
                        if (bus.eng_done_i) r_out <= bus.eng_out_vec_i;
                        r_done  <= NUM_REQ'(1) << r_owner;
                        r_state <= RESP;
                    end
                end
                default: begin
                    r_rr    <= r_owner;
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
    assign bus.grant_o       = r_grant;
    assign bus.done_o        = r_done;
    assign bus.out_vec_o     = r_out;
    assign bus.busy_o        = r_state != IDLE;
    assign bus.eng_start_o   = r_start;
    assign bus.eng_in_vec_o  = r_in;
    assign bus.weight_addr_o = {r_owner, bus.eng_weight_addr_i};
endmodule

// File: tb/tb_matvec_sched.sv
// tb_matvec_sched: randomized bench for matvec_sched with a behavioural matvec engine and weight ROM.
// With MATVEC_SCHED_TIMEOUT_EN defined it also exercises the watchdog (TIMEOUT=20).
module tb_matvec_sched;
    localparam int N = 4, ID = 4, OD = 2;
    localparam int AW = $clog2(OD * ID), IW = $clog2(N), WN = N * OD * ID;
    logic clk = 1'b0, rst = 1'b1;
    int total = 0, bad = 0;
    int model_rr = N - 1;
    logic signed [7:0] wrom [WN];
    logic e_done = 1'b0, x_done = 1'b0;
    logic [OD*8-1:0] e_out = '0, x_out = '0;
    logic [AW-1:0] e_addr = '0;
    bit stub = 1'b0;

    matvec_sched_if #(.NUM_REQ(N), .IN_DIM(ID), .OUT_DIM(OD)) bus ();
    matvec_sched #(
        .NUM_REQ(N), .IN_DIM(ID), .OUT_DIM(OD)
`ifdef MATVEC_SCHED_TIMEOUT_EN
        , .TIMEOUT(20)
`endif
    ) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    assign bus.eng_done_i        = e_done | x_done;
    assign bus.eng_out_vec_i     = x_done ? x_out : e_out;
    assign bus.eng_weight_addr_i = e_addr;
    always #5 clk = ~clk;

    function automatic logic [OD*8-1:0] model(input logic [ID*8-1:0] v, input int bank);
        logic [OD*8-1:0] r;
        int acc;
        r = '0;
        for (int o = 0; o < OD; o++) begin
            acc = 0;
            for (int i = 0; i < ID; i++) acc += int'($signed(v[i*8 +: 8])) * int'(wrom[bank*OD*ID + o*ID + i]);
            acc = acc >>> 7;
            acc = acc > 127 ? 127 : (acc < -128 ? -128 : acc);
            r[o*8 +: 8] = acc[7:0];
        end
        return r;
    endfunction

    function automatic int next_owner(input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) if (req[(model_rr + k) % N]) return (model_rr + k) % N;
        return -1;
    endfunction

    function automatic logic [ID*8-1:0] rvec();
        logic [ID*8-1:0] v;
        for (int i = 0; i < ID; i++) v[i*8 +: 8] = 8'($urandom);
        return v;
    endfunction

    // Engine: sweeps weight addresses one per cycle, reads the ROM through weight_addr_o, done in start+OD*ID+1.
    task automatic run_engine();
        logic [ID*8-1:0] v;
        int acc [OD];
        v = bus.eng_in_vec_o;
        for (int o = 0; o < OD; o++) acc[o] = 0;
        for (int k = 0; k < OD * ID; k++) begin
            @(negedge clk);
            if (rst) return;
            e_addr = AW'(k);
            #1;
            acc[k / ID] += int'($signed(v[(k % ID)*8 +: 8])) * int'(wrom[bus.weight_addr_o]);
        end
        @(negedge clk);
        if (rst) return;
        for (int o = 0; o < OD; o++) begin
            acc[o] = acc[o] >>> 7;
            acc[o] = acc[o] > 127 ? 127 : (acc[o] < -128 ? -128 : acc[o]);
            e_out[o*8 +: 8] = 8'(acc[o]);
        end
        e_done = 1'b1;
        @(negedge clk);
        e_done = 1'b0;
    endtask

    initial forever begin
        @(negedge clk);
        if (bus.eng_start_o === 1'b1 && !stub && !rst) run_engine();
    end

    task automatic wait_grant(output int n);
        n = 0;
        while (bus.grant_o == '0 && n < 50) begin @(negedge clk); n++; end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done_o == '0 && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        int n;
        bus.req_i = '0;
        bus.in_vec_i = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.grant_o !== '0) begin bad++; $display("FAIL rst_grant got=%b exp=0", bus.grant_o); end
        total++; if (bus.done_o !== '0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done_o); end
        total++; if (bus.out_vec_o !== '0) begin bad++; $display("FAIL rst_out got=%h exp=0", bus.out_vec_o); end
        total++; if (bus.busy_o !== 1'b0 || bus.eng_start_o !== 1'b0) begin bad++; $display("FAIL rst_busy_start got=%b%b exp=00", bus.busy_o, bus.eng_start_o); end
        total++; if (bus.eng_in_vec_o !== '0) begin bad++; $display("FAIL rst_in_vec got=%h exp=0", bus.eng_in_vec_o); end
        total++; if (bus.weight_addr_o[IW+AW-1:AW] !== '0) begin bad++; $display("FAIL rst_bank got=%0d exp=0", bus.weight_addr_o[IW+AW-1:AW]); end
        rst = 1'b0;
        for (int k = 0; k < N; k++) bus.in_vec_i[k*ID*8 +: ID*8] = rvec();
        for (int a = 0; a < WN; a++) wrom[a] = 8'($urandom);
        bus.req_i = 4'b0010;
        @(negedge clk);
        total++; if (bus.grant_o !== 4'b0010) begin bad++; $display("FAIL pre_grant got=%b exp=0010", bus.grant_o); end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if ({bus.grant_o, bus.done_o, bus.busy_o, bus.eng_start_o} !== '0 || bus.eng_in_vec_o !== '0 || bus.out_vec_o !== '0)
            begin bad++; $display("FAIL async_rst got=%b%b%b%b in=%h out=%h exp=0", bus.grant_o, bus.done_o, bus.busy_o, bus.eng_start_o, bus.eng_in_vec_o, bus.out_vec_o); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_rr = N - 1;
        bus.req_i = 4'b0001;
        @(negedge clk);
        total++; if (bus.grant_o !== 4'b0001 || bus.eng_start_o !== 1'b1) begin bad++; $display("FAIL post_rst_grant got=%b/%b exp=0001/1", bus.grant_o, bus.eng_start_o); end
        wait_done(n);
        total++; if (bus.done_o !== 4'b0001 || bus.out_vec_o !== model(bus.in_vec_i[0 +: ID*8], 0))
            begin bad++; $display("FAIL post_rst_job got=%b/%h exp=0001/%h", bus.done_o, bus.out_vec_o, model(bus.in_vec_i[0 +: ID*8], 0)); end
        bus.req_i = '0;
        model_rr = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        logic [ID*8-1:0] v;
        for (int a = 0; a < OD * ID; a++) wrom[2*OD*ID + a] = 8'sd2;
        v = {ID{8'h40}};
        bus.in_vec_i[2*ID*8 +: ID*8] = v;
        bus.req_i = 4'b0100;
        @(negedge clk);
        total++; if (bus.grant_o !== 4'b0100 || bus.eng_start_o !== 1'b1 || bus.busy_o !== 1'b1)
            begin bad++; $display("FAIL single_start got=%b/%b/%b exp=0100/1/1", bus.grant_o, bus.eng_start_o, bus.busy_o); end
        total++; if (bus.weight_addr_o[IW+AW-1:AW] !== 2'd2) begin bad++; $display("FAIL single_bank got=%0d exp=2", bus.weight_addr_o[IW+AW-1:AW]); end
        total++; if (bus.eng_in_vec_o !== v) begin bad++; $display("FAIL single_latch got=%h exp=%h", bus.eng_in_vec_o, v); end
        @(negedge clk);
        total++; if (bus.eng_start_o !== 1'b0) begin bad++; $display("FAIL single_start_pulse got=%b exp=0", bus.eng_start_o); end
        wait_done(n);
        total++; if (n !== OD * ID + 1) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", n + 1, OD * ID + 2); end
        total++; if (bus.done_o !== 4'b0100) begin bad++; $display("FAIL single_done got=%b exp=0100", bus.done_o); end
        total++; if (bus.out_vec_o !== {OD{8'h04}}) begin bad++; $display("FAIL single_out got=%h exp=%h", bus.out_vec_o, {OD{8'h04}}); end
        bus.req_i = '0;
        model_rr = 2;
        @(negedge clk);
        total++; if (bus.done_o !== '0 || bus.grant_o !== '0 || bus.busy_o !== 1'b0)
            begin bad++; $display("FAIL single_end got=%b/%b/%b exp=0/0/0", bus.done_o, bus.grant_o, bus.busy_o); end
        total++; if (bus.weight_addr_o[IW+AW-1:AW] !== 2'd2) begin bad++; $display("FAIL idle_bank got=%0d exp=2", bus.weight_addr_o[IW+AW-1:AW]); end
    endtask

    task automatic test_spurious();
        logic [OD*8-1:0] keep;
        keep = bus.out_vec_o;
        x_out = ~keep;
        x_done = 1'b1;
        @(negedge clk);
        x_done = 1'b0;
        @(negedge clk);
        total++; if (bus.done_o !== '0 || bus.busy_o !== 1'b0 || bus.out_vec_o !== keep)
            begin bad++; $display("FAIL spurious_done got=%b/%b/%h exp=0/0/%h", bus.done_o, bus.busy_o, bus.out_vec_o, keep); end
    endtask

    task automatic test_rr();
        int n;
        int order [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rr = N - 1;
        for (int a = 0; a < WN; a++) wrom[a] = 8'($urandom);
        for (int k = 0; k < N; k++) bus.in_vec_i[k*ID*8 +: ID*8] = rvec();
        bus.req_i = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_grant(n);
            total++; if (n !== 1 || bus.grant_o !== N'(1) << order[j])
                begin bad++; $display("FAIL rr_grant%0d got=%b after %0d exp=%b after 1", j, bus.grant_o, n, N'(1) << order[j]); end
            total++; if (next_owner(bus.req_i) !== order[j]) begin bad++; $display("FAIL rr_model%0d got=%0d exp=%0d", j, next_owner(bus.req_i), order[j]); end
            wait_done(n);
            total++; if (bus.done_o !== N'(1) << order[j] || bus.out_vec_o !== model(bus.in_vec_i[order[j]*ID*8 +: ID*8], order[j]))
                begin bad++; $display("FAIL rr_done%0d got=%b/%h exp=%b/%h", j, bus.done_o, bus.out_vec_o, N'(1) << order[j], model(bus.in_vec_i[order[j]*ID*8 +: ID*8], order[j])); end
            model_rr = order[j];
            @(negedge clk);
            total++; if (bus.grant_o !== '0 || bus.done_o !== '0) begin bad++; $display("FAIL rr_gap%0d got=%b/%b exp=0/0", j, bus.grant_o, bus.done_o); end
        end
        bus.req_i = '0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_drop();
        int n;
        logic [ID*8-1:0] v;
        v = rvec();
        bus.in_vec_i[3*ID*8 +: ID*8] = v;
        bus.req_i = 4'b1000;
        wait_grant(n);
        total++; if (bus.grant_o !== 4'b1000) begin bad++; $display("FAIL drop_grant got=%b exp=1000", bus.grant_o); end
        bus.in_vec_i[3*ID*8 +: ID*8] = ~v;
        bus.req_i = '0;
        wait_done(n);
        total++; if (bus.done_o !== 4'b1000 || bus.out_vec_o !== model(v, 3) || bus.eng_in_vec_o !== v)
            begin bad++; $display("FAIL drop_result got=%b/%h/%h exp=1000/%h/%h", bus.done_o, bus.out_vec_o, bus.eng_in_vec_o, model(v, 3), v); end
        model_rr = 3;
        @(negedge clk);
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b exp=0", bus.busy_o); end
    endtask

    task automatic test_sat();
        int n;
        logic [7:0] ins [2] = '{8'h7f, 8'h80};
        logic [7:0] outs [2] = '{8'h7f, 8'h80};
        for (int a = 0; a < OD * ID; a++) wrom[1*OD*ID + a] = 8'sd127;
        for (int c = 0; c < 2; c++) begin
            bus.in_vec_i[1*ID*8 +: ID*8] = {ID{ins[c]}};
            bus.req_i = 4'b0010;
            wait_grant(n);
            wait_done(n);
            total++; if (bus.done_o !== 4'b0010 || bus.out_vec_o !== {OD{outs[c]}})
                begin bad++; $display("FAIL sat%0d got=%b/%h exp=0010/%h", c, bus.done_o, bus.out_vec_o, {OD{outs[c]}}); end
            bus.req_i = '0;
            model_rr = 1;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int n, w;
        logic [N-1:0] r;
        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < WN; a++) wrom[a] = 8'($urandom);
            for (int k = 0; k < N; k++) bus.in_vec_i[k*ID*8 +: ID*8] = rvec();
            r = N'($urandom_range(1, (1 << N) - 1));
            w = next_owner(r);
            bus.req_i = r;
            wait_grant(n);
            total++; if (n !== 1 || bus.grant_o !== N'(1) << w) begin bad++; $display("FAIL rand_grant%0d req=%b got=%b exp=%b", it, r, bus.grant_o, N'(1) << w); end
            wait_done(n);
            total++; if (bus.done_o !== N'(1) << w || bus.out_vec_o !== model(bus.in_vec_i[w*ID*8 +: ID*8], w))
                begin bad++; $display("FAIL rand_done%0d got=%b/%h exp=%b/%h", it, bus.done_o, bus.out_vec_o, N'(1) << w, model(bus.in_vec_i[w*ID*8 +: ID*8], w)); end
            bus.req_i = '0;
            model_rr = w;
            @(negedge clk);
        end
    endtask

`ifdef MATVEC_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        logic [OD*8-1:0] keep;
        stub = 1'b1;
        keep = bus.out_vec_o;
        bus.req_i = 4'b0001;
        wait_grant(n);
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL tmo_err_pre got=%b exp=0", bus.err_o); end
        wait_done(n);
        total++; if (n !== 21 || bus.done_o !== 4'b0001) begin bad++; $display("FAIL tmo_done got=%b after %0d exp=0001 after 21", bus.done_o, n); end
        total++; if (bus.err_o !== 1'b1 || bus.out_vec_o !== keep) begin bad++; $display("FAIL tmo_err got=%b/%h exp=1/%h", bus.err_o, bus.out_vec_o, keep); end
        bus.req_i = '0;
        repeat (5) @(negedge clk);
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b exp=1", bus.err_o); end
        rst = 1'b1;
        #1;
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", bus.err_o); end
        @(negedge clk);
        rst = 1'b0;
        stub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_spurious();
        test_rr();
        test_drop();
        test_sat();
        test_random();
`ifdef MATVEC_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matvec_sched.md
Name: matvec_sched

Overview:
- Round-robin scheduler that shares one matvec_int8 engine and its weight BRAM among NUM_REQ requesters (e.g. Q/K/V/O projections).
- Arbitrates requests and latches the winner's input vector into the engine.
- Pulses engine start, offsets the engine's weight address into the winner's weight bank, and returns the result with a per-requester done pulse.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, at least 2.
- IN_DIM, 128, engine input vector length (int8 elements).
- OUT_DIM, 128, engine output vector length (int8 elements).
- Derived: AW = $clog2(OUT_DIM*IN_DIM); IW = $clog2(NUM_REQ).

Ports:
- clk_i  in  1  clock; all logic on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  NUM_REQ  per-requester request level.
- in_vec_i  in  NUM_REQ*IN_DIM*8  requester k's vector in slice [k*IN_DIM*8 +: IN_DIM*8].
- grant_o  out  NUM_REQ  one-hot owner of the engine; held from START through RESP.
- done_o  out  NUM_REQ  one-cycle pulse to the owner when out_vec_o is valid.
- out_vec_o  out  OUT_DIM*8  last result; holds until the next capture.
- busy_o  out  1  high in any state other than IDLE.
- eng_start_o  out  1  start pulse to the engine.
- eng_in_vec_o  out  IN_DIM*8  latched input vector to the engine.
- eng_weight_addr_i  in  AW  engine weight address.
- eng_out_vec_i  in  OUT_DIM*8  engine result.
- eng_done_i  in  1  engine done pulse.
- weight_addr_o  out  IW+AW  BRAM address, combinational {owner_idx, eng_weight_addr_i}.

Behaviour:
- Reset (async, any state): state=IDLE; grant_o=0; done_o=0; out_vec_o=0; eng_start_o=0; eng_in_vec_o=0; busy_o=0; owner_idx=0; rr_ptr=NUM_REQ-1, so req 0 has first priority.
- IDLE:
  - If any req_i is high, pick the first set bit searching from rr_ptr+1 with modulo wrap.
  - Latch owner_idx and that requester's in_vec_i into eng_in_vec_o; set grant_o one-hot; go to START.
  - Requester input vectors may change after this edge.
- START (1 cycle): eng_start_o=1; go to RUN.
- RUN: eng_start_o=0; wait for eng_done_i. On eng_done_i, capture eng_out_vec_i into out_vec_o and go to RESP.
- RESP (1 cycle):
  - done_o[owner_idx]=1, aligned with the first cycle out_vec_o shows the new value.
  - rr_ptr<=owner_idx; grant_o clears on exit; go to IDLE.
- Latency:
  - req sampled at edge T gives grant_o and eng_start_o high in cycle T+1.
  - eng_done_i in cycle D gives done_o in cycle D+1.
  - Earliest next grant is at edge D+2. With matvec_int8, D = start cycle + OUT_DIM*IN_DIM + 1.
- Handshake: a requester holds req_i until it sees done_o, then drops it in the next cycle. If req_i is still high in IDLE, it is treated as a new request, lowest priority relative to other pending requesters.
- Boundary conditions:
  - req_i dropped mid-operation: ignored; the job completes and done_o still pulses.
  - eng_done_i outside RUN: ignored.
  - Simultaneous requests: strictly round-robin; no requester starves. Worst case wait is NUM_REQ-1 jobs.
  - weight_addr_o upper IW bits equal owner_idx in every state, including IDLE.

Optional Feature:
- Macro MATVEC_SCHED_TIMEOUT_EN adds a parameter TIMEOUT (default OUT_DIM*IN_DIM+16) and an output port err_o (1 bit, reset 0).
- With the macro defined:
  - A cycle counter clears on START and increments in RUN.
  - If it reaches TIMEOUT without eng_done_i: leave out_vec_o unchanged, set sticky err_o=1, and go to RESP, so done_o still pulses.
  - err_o clears only on reset.
- Without the macro: no counter and no err_o port; RUN waits indefinitely.

Test Plan:
- Reset mid-RUN (NUM_REQ=4, IN_DIM=4, OUT_DIM=2, real matvec_int8 plus weight ROM model) -> all outputs 0 on the same edge; after release, req_i=4'b0001 is granted to req 0 first.
- Single request from req 2 with in_vec all 8'sd64 and bank-2 weights all 8'sd2 -> eng_start_o one cycle after req; weight_addr_o[IW+AW-1:AW]=2; each out element 64*2*4>>>7=4; done_o=4'b0100 for exactly one cycle.
- req_i=4'b1111 held continuously -> grant order 0,1,2,3,0; each done_o pulse is one-hot, and the next grant follows 2 cycles after each eng_done_i.
- Owner changes in_vec_i and drops req_i one cycle after grant -> result reflects the latched vector; done_o still pulses.
- Saturation: in_vec all 127, weights all 127 -> out element 127; in_vec all -128, weights all 127 -> -128.
- With MATVEC_SCHED_TIMEOUT_EN and TIMEOUT=20, a stub engine that never asserts done -> done_o pulses 21 cycles after START; err_o=1 and stays high until reset.
